gen_logic: RTL and testbench
============================

GEN_LOGIC -- requirements
Module: gen_logic

Interface
REQ-001 Parameter DW, default 32, data word width in bits.
REQ-002 Parameter GAP, default 0, idle cycles inserted after each accepted word except the last (0 = back-to-back).
REQ-003 Parameter CW, default 16, width of the word-count input and internal remaining counter.
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  request to begin a burst, sampled only in IDLE.
REQ-007 Port num_words  input  CW  burst length, latched with start.
REQ-008 Port down_valid  output  1  word available to downstream checker.
REQ-009 Port down_data  output  DW  current word.
REQ-010 Port down_ready  input  1  downstream accepts; transfer = down_valid && down_ready.
REQ-011 Port busy  output  1  high in any state other than IDLE.
REQ-012 Port done  output  1  single-cycle pulse at burst completion.

Function
REQ-013 FSM states SHALL be IDLE, SEND, GAP, FIN; down_valid SHALL be high only in SEND.
REQ-014 IDLE: start=1 with num_words!=0 SHALL latch num_words into remaining, load data with the initial pattern value, and enter SEND; down_valid rises the cycle after start.
REQ-015 IDLE: start=1 with num_words==0 SHALL enter FIN directly (no transfer, done pulse next cycle).
REQ-016 start SHALL be ignored outside IDLE; num_words changes outside IDLE SHALL have no effect.
REQ-017 SEND: once down_valid is high, down_valid and down_data SHALL stay stable until a transfer occurs, regardless of down_ready.
REQ-018 On a transfer, data SHALL advance to the next pattern value and remaining SHALL decrement by 1.
REQ-019 Transfer with remaining==1 SHALL enter FIN; otherwise GAP==0 stays in SEND (one word per cycle at full throughput) and GAP>0 enters GAP.
REQ-020 GAP SHALL hold down_valid low for exactly GAP cycles, then return to SEND.
REQ-021 FIN SHALL assert done for exactly one cycle, then enter IDLE; start in that FIN cycle SHALL be ignored.
REQ-022 Counter pattern: first word 0, increment by 1 modulo 2^DW (wraps 2^DW-1 -> 0).
REQ-023 down_data SHALL retain the last-sent word's successor while IDLE; a new burst always restarts from the initial value.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, down_valid=0, down_data=0, busy=0, done=0, remaining=0, gap counter=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block waits for a new start.

Configuration
REQ-026 With GEN_LOGIC_LFSR_EN defined, the pattern SHALL be a 32-bit Galois LFSR (polynomial and nonzero seed from package), first word = seed, down_data = LFSR value zero-extended or truncated to DW; without it, the counter pattern of REQ-022 applies.
REQ-027 Macro choice SHALL not alter handshake timing, state sequencing, or reset values (LFSR register resets to seed internally; down_data output still 0).

Structure
REQ-028 Package gen_logic_pkg SHALL hold the FSM state typedef, LFSR polynomial constant (32'h8020_0003) and LFSR seed constant (32'h0000_0001).
REQ-029 The pattern generator SHALL be a sub-module gen_pattern (load, advance, value), selecting counter or LFSR under GEN_LOGIC_LFSR_EN.

Verification
REQ-030 GAP=0, num_words=4, down_ready=1: start at cycle 0 -> down_data 0,1,2,3 on cycles 1-4, done at cycle 5, busy low cycle 6.
REQ-031 GAP=2, num_words=3, down_ready=1: valid high cycles 1,4,7 with data 0,1,2; done cycle 8.
REQ-032 num_words=2, down_ready held low 5 cycles after valid rises: down_data stays 0 and down_valid stays high all 5 cycles; then 0,1 transfer and done.
REQ-033 start with num_words=0 -> no down_valid, done one cycle after start; start pulses during a burst -> no extra words.
REQ-034 rst_n pulsed low mid-burst after 2 of 5 words -> outputs 0 immediately, no done; next start with num_words=1 sends data 0.
REQ-035 Connected to the downstream checker with DELAY=3, num_words=8: all 8 words accepted in order, each transfer separated by the checker's back-pressure, done asserted once.

Source files
------------

// File: rtl/gen_logic_pkg.sv
// Shared definitions for the gen_logic burst generator: FSM states and LFSR constants.
// The LFSR constants are used only when GEN_LOGIC_LFSR_EN is defined.
package gen_logic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

   // One right-shifting Galois step: feedback taps are applied when bit 0 falls out.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ LFSR_POLY;
      end
      return n;
   endfunction

endpackage

// File: rtl/gen_pattern.sv
// Word pattern source for gen_logic: a wrapping counter by default, or a 32-bit Galois
// LFSR when GEN_LOGIC_LFSR_EN is defined. The value register always resets to zero.
module gen_pattern
   import gen_logic_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          advance,
   output logic [DW-1:0] value
);

`ifdef GEN_LOGIC_LFSR_EN

   logic [31:0] lfsr;
   logic [31:0] lfsr_nxt;

   assign lfsr_nxt = lfsr_step(lfsr);

   // The LFSR state keeps the seed across reset so it is never stuck at zero,
   // while the visible word still comes out of reset as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr  <= LFSR_SEED;
         value <= '0;
      end else if (load) begin
         lfsr  <= LFSR_SEED;
         value <= DW'(LFSR_SEED);
      end else if (advance) begin
         lfsr  <= lfsr_nxt;
         value <= DW'(lfsr_nxt);
      end
   end

`else

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= '0;
      end else if (advance) begin
         value <= value + DW'(1);
      end
   end

`endif

endmodule

// File: rtl/gen_logic.sv
// Burst generator: on start, emits num_words pattern words over a valid/ready link with
// an optional idle gap between words. Define GEN_LOGIC_LFSR_EN for an LFSR pattern.
module gen_logic
   import gen_logic_pkg::*;
#(
   parameter int DW  = 32,
   parameter int GAP = 0,
   parameter int CW  = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] num_words,
   output logic          down_valid,
   output logic [DW-1:0] down_data,
   input  logic          down_ready,
   output logic          busy,
   output logic          done
);

   // Gap counter needs at least one bit even when the gap feature is unused.
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] remaining;
   logic [GW-1:0] gap_cnt;
   logic          gap_last;
   logic          xfer;
   logic          load;

   assign down_valid = (state == ST_SEND);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_FIN);
   assign xfer       = down_valid && down_ready;
   assign gap_last   = (gap_cnt == GW'(GAP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  next_state = ST_FIN;
               end else begin
                  next_state = ST_SEND;
                  load       = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (remaining == CW'(1)) begin
                  next_state = ST_FIN;
               end else if (GAP == 0) begin
                  next_state = ST_SEND;
               end else begin
                  next_state = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               next_state = ST_SEND;
            end
         end
         ST_FIN: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Word and gap bookkeeping; the gap counter is parked at zero outside ST_GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         gap_cnt   <= '0;
      end else begin
         if (load) begin
            remaining <= num_words;
         end else if (xfer) begin
            remaining <= remaining - CW'(1);
         end
         if (state == ST_GAP && !gap_last) begin
            gap_cnt <= gap_cnt + GW'(1);
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   gen_pattern #(
      .DW(DW)
   ) u_pattern (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .advance(xfer),
      .value  (down_data)
   );

endmodule

// File: tb/tb_gen_logic.sv
// Self-checking bench for gen_logic: a GAP=0/DW=32 instance with a scoreboard on its
// transfers, and a GAP=2/DW=4 instance for gap timing and counter wrap.
module tb_gen_logic;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num_words;
   logic        down_valid;
   logic [31:0] down_data;
   logic        down_ready;
   logic        busy;
   logic        done;

   logic        g_start;
   logic [15:0] g_num;
   logic        g_valid;
   logic [3:0]  g_data;
   logic        g_ready;
   logic        g_busy;
   logic        g_done;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   logic [31:0] exp_q[$];
   int          xfer_cyc[$];

   always #5 clk = ~clk;

   gen_logic #(.DW(32), .GAP(0), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
      .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready),
      .busy(busy), .done(done)
   );

   gen_logic #(.DW(4), .GAP(2), .CW(16)) dut_gap (
      .clk(clk), .rst_n(rst_n), .start(g_start), .num_words(g_num),
      .down_valid(g_valid), .down_data(g_data), .down_ready(g_ready),
      .busy(g_busy), .done(g_done)
   );

   // Reference pattern: word i of a burst, masked to w bits.
   function automatic logic [31:0] pat(input int i, input int w);
      logic [31:0] s;
`ifdef GEN_LOGIC_LFSR_EN
      s = 32'h0000_0001;
      for (int k = 0; k < i; k++) begin
         s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      end
`else
      s = 32'(i);
`endif
      if (w < 32) begin
         s = s & ((32'h1 << w) - 32'h1);
      end
      return s;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every transfer on the main instance pops one expected word.
   always @(negedge clk) begin
      logic [31:0] e;
      if (down_valid && down_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got word %h, expected no transfer", down_data);
         end else begin
            e = exp_q.pop_front();
            if (down_data !== e) begin
               n_fail++;
               $display("FAIL sb_word: got %h, expected %h", down_data, e);
            end
         end
         xfer_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; num_words = '0; down_ready = 1'b1;
      g_start = 1'b0; g_num = '0; g_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({down_valid, busy, done} !== 3'b000 || down_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_main: got v/b/d=%b%b%b data=%h, expected 000 data=0",
                  down_valid, busy, done, down_data);
      end
      n_checks++;
      if ({g_valid, g_busy, g_done} !== 3'b000 || g_data !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_gap: got v/b/d=%b%b%b data=%h, expected 000 data=0",
                  g_valid, g_busy, g_done, g_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ev;
      start = 1'b1; num_words = 16'd4; down_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(pat(i, 32));
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         ev = (c >= 1 && c <= 4);
         n_checks++;
         if (down_valid !== ev || (ev && down_data !== pat(c - 1, 32))) begin
            n_fail++;
            $display("FAIL basic_word c%0d: got v=%b data=%h, expected v=%b data=%h",
                     c, down_valid, down_data, ev, pat(c - 1, 32));
         end
         n_checks++;
         if (done !== (c == 5) || busy !== (c <= 5)) begin
            n_fail++;
            $display("FAIL basic_ctrl c%0d: got done=%b busy=%b, expected done=%b busy=%b",
                     c, done, busy, (c == 5), (c <= 5));
         end
      end
      n_checks++;
      if (down_data !== pat(4, 32) || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL basic_idle_data: got %h (queue %0d), expected %h (queue 0)",
                  down_data, exp_q.size(), pat(4, 32));
      end
   endtask

   task automatic test_gap();
      bit ev;
      logic [3:0] ed;
      @(posedge clk); #1;
      g_start = 1'b1; g_num = 16'd3; g_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         g_start = 1'b0;
         @(negedge clk);
         ev = (c == 1 || c == 4 || c == 7);
         ed = 4'(pat((c - 1) / 3, 4));
         n_checks++;
         if (g_valid !== ev || (ev && g_data !== ed)) begin
            n_fail++;
            $display("FAIL gap_word c%0d: got v=%b data=%h, expected v=%b data=%h",
                     c, g_valid, g_data, ev, ed);
         end
         n_checks++;
         if (g_done !== (c == 8) || g_busy !== (c <= 8)) begin
            n_fail++;
            $display("FAIL gap_ctrl c%0d: got done=%b busy=%b, expected done=%b busy=%b",
                     c, g_done, g_busy, (c == 8), (c <= 8));
         end
      end
   endtask

   task automatic test_wrap();
      int k = 0;
      bit seen = 1'b0;
      logic [3:0] ed;
      @(posedge clk); #1;
      g_start = 1'b1; g_num = 16'd18;
      @(posedge clk); #1;
      g_start = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (g_valid && g_ready) begin
            ed = 4'(pat(k, 4));
            n_checks++;
            if (g_data !== ed) begin
               n_fail++;
               $display("FAIL wrap_word %0d: got %h, expected %h", k, g_data, ed);
            end
            k++;
         end
         if (g_done) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (!seen || k != 18) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d words done=%b, expected 18 words done=1", k, seen);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; num_words = 16'd2; down_ready = 1'b0;
      exp_q.push_back(pat(0, 32)); exp_q.push_back(pat(1, 32));
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (down_valid !== 1'b1 || down_data !== pat(0, 32)) begin
            n_fail++;
            $display("FAIL bp_hold %0d: got v=%b data=%h, expected v=1 data=%h",
                     c, down_valid, down_data, pat(0, 32));
         end
         @(posedge clk); #1;
      end
      down_ready = 1'b1;
      wait_done(20, ok);
      @(posedge clk); #1;
      n_checks++;
      if (!ok || done_cnt != d0 + 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_finish: got done_seen=%b pulses=%0d left=%0d, expected 1 1 0",
                  ok, done_cnt - d0, exp_q.size());
      end
   endtask

   task automatic test_zero_and_ignored();
      int d0;
      @(posedge clk); #1;
      start = 1'b1; num_words = 16'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (down_valid !== 1'b0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_fin: got v=%b done=%b, expected v=0 done=1", down_valid, done);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle: got done=%b busy=%b, expected 0 0", done, busy);
      end
      @(posedge clk); #1;
      d0 = done_cnt;
      start = 1'b1; num_words = 16'd3;
      for (int i = 0; i < 3; i++) exp_q.push_back(pat(i, 32));
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         num_words = 16'(7 + c);
         if (c == 5) start = 1'b0;
         @(negedge clk);
         n_checks++;
         if (down_valid !== (c <= 3) || done !== (c == 4) || busy !== (c <= 4)) begin
            n_fail++;
            $display("FAIL ign_c%0d: got v=%b done=%b busy=%b, expected v=%b done=%b busy=%b",
                     c, down_valid, done, busy, (c <= 3), (c == 4), (c <= 4));
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (exp_q.size() != 0 || done_cnt != d0 + 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_total: got left=%0d pulses=%0d busy=%b, expected 0 1 0",
                  exp_q.size(), done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int d0;
      @(posedge clk); #1;
      start = 1'b1; num_words = 16'd5; down_ready = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back(pat(i, 32));
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({down_valid, busy, done} !== 3'b000 || down_data !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_async: got v/b/d=%b%b%b data=%h, expected 000 data=0",
                  down_valid, busy, done, down_data);
      end
      n_checks++;
      if (exp_q.size() != 3) begin
         n_fail++;
         $display("FAIL rstmid_sent: got %0d words pending, expected 3", exp_q.size());
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_nodone: got pulses=%0d busy=%b, expected 0 0", done_cnt - d0, busy);
      end
      start = 1'b1; num_words = 16'd1;
      exp_q.push_back(pat(0, 32));
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (down_valid !== 1'b1 || down_data !== pat(0, 32)) begin
         n_fail++;
         $display("FAIL rstmid_restart: got v=%b data=%h, expected v=1 data=%h",
                  down_valid, down_data, pat(0, 32));
      end
      wait_done(10, ok);
      @(posedge clk); #1;
      n_checks++;
      if (!ok || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid_finish: got done_seen=%b left=%0d, expected 1 0", ok, exp_q.size());
      end
   endtask

   task automatic test_checker();
      int d0 = done_cnt;
      int wcnt = 0;
      bit seen = 1'b0;
      xfer_cyc.delete();
      @(posedge clk); #1;
      start = 1'b1; num_words = 16'd8; down_ready = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(pat(i, 32));
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (down_valid) begin
            if (wcnt == 3) begin
               down_ready = 1'b1; wcnt = 0;
            end else begin
               down_ready = 1'b0; wcnt++;
            end
         end else begin
            down_ready = 1'b0;
         end
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      @(posedge clk); #1;
      down_ready = 1'b1;
      n_checks++;
      if (!seen || done_cnt != d0 + 1 || exp_q.size() != 0 || xfer_cyc.size() != 8) begin
         n_fail++;
         $display("FAIL chk_total: got done_seen=%b pulses=%0d left=%0d xfers=%0d, expected 1 1 0 8",
                  seen, done_cnt - d0, exp_q.size(), xfer_cyc.size());
      end
      for (int i = 1; i < xfer_cyc.size(); i++) begin
         n_checks++;
         if (xfer_cyc[i] - xfer_cyc[i - 1] != 4) begin
            n_fail++;
            $display("FAIL chk_spacing %0d: got %0d cycles, expected 4",
                     i, xfer_cyc[i] - xfer_cyc[i - 1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_wrap();
      test_backpressure();
      test_zero_and_ignored();
      test_reset_mid();
      test_checker();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
